// File: rtl/osmanip_mem_pkg.sv
// osmanip_mem_pkg: shared constants and types for the osmanip RAM arbiter.
//   ADDR_W / DATA_W : default RAM word address and data widths
//   RD_LATENCY      : cycles from read accept to readdatavalid
//   owner_t         : which requester issued an access (0 = HPS, 1 = cube engine)
//   rd_tag_t        : read-return tag carried down the latency pipeline
package osmanip_mem_pkg;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 32;
  localparam int RD_LATENCY = 2;

  typedef logic owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/osmanip_rr_arb2.sv
// osmanip_rr_arb2: two-way per-cycle grant with a registered round-robin pointer.
// Config macro: OSMANIP_MEM_ARB_FIXED_PRI_EN -> pointer removed, requester 0
// always wins contention.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req[1:0]    : active requests (already qualified by reset in the parent)
//   gnt_valid   : some request is granted this cycle
//   gnt_owner   : index of the granted requester
//
// rr_q | meaning
// 0    | requester 0 wins the next contended cycle
// 1    | requester 1 wins the next contended cycle
module osmanip_rr_arb2
  import osmanip_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output owner_t     gnt_owner
);

`ifdef OSMANIP_MEM_ARB_FIXED_PRI_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    gnt_valid = |req;
    gnt_owner = ~req[0] & req[1];
  end
`else
  owner_t rr_q, rr_d;

  always_comb begin
    gnt_valid = |req;
    gnt_owner = 1'b0;
    rr_d      = rr_q;
    if (&req) begin
      gnt_owner = rr_q;
      // pointer moves to the loser so it wins the next contended cycle
      rr_d      = ~rr_q;
    end else if (req[1]) begin
      gnt_owner = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`endif

endmodule

// File: rtl/osmanip_mem_arbiter.sv
// osmanip_mem_arbiter: shares one single-port RAM (1-cycle read latency) between
// the HPS Avalon master (m0) and the cube-state engine (m1).
// Config macro: OSMANIP_MEM_ARB_FIXED_PRI_EN (fixed m0 priority, see osmanip_rr_arb2).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mX_read/write/address/byteenable/writedata : Avalon-MM pipelined commands
//   mX_waitrequest        : command not accepted this cycle
//   mX_readdata/valid     : registered read return, fixed latency 2
//   mem_*                 : RAM port, driven combinationally from the winner
module osmanip_mem_arbiter #(
  parameter int ADDR_W = osmanip_mem_pkg::ADDR_W,
  parameter int DATA_W = osmanip_mem_pkg::DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  import osmanip_mem_pkg::*;

  logic                         m0_act, m1_act;
  logic                         gnt_valid;
  owner_t                       gnt_owner;
  rd_tag_t                      new_tag;
  rd_tag_t [RD_LATENCY-1:0]     tag_q, tag_d;
  logic [DATA_W-1:0]            m0_readdata_q, m0_readdata_d;
  logic [DATA_W-1:0]            m1_readdata_q, m1_readdata_d;

  // reset masks requests so waitrequest and mem_* read 0 while it is held
  assign m0_act = ~reset & (m0_read | m0_write);
  assign m1_act = ~reset & (m1_read | m1_write);

  osmanip_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({m1_act, m0_act}),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  assign m0_waitrequest = m0_act & ~(gnt_valid & (gnt_owner == 1'b0));
  assign m1_waitrequest = m1_act & ~(gnt_valid & (gnt_owner == 1'b1));
  assign mem_clken      = 1'b1;

  // read+write together counts as a write, so write alone picks the direction
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    new_tag        = '0;
    if (gnt_valid) begin
      mem_chipselect = 1'b1;
      if (gnt_owner) begin
        mem_write      = m1_write;
        mem_address    = m1_address;
        mem_writedata  = m1_writedata;
        mem_byteenable = m1_write ? m1_byteenable : '1;
      end else begin
        mem_write      = m0_write;
        mem_address    = m0_address;
        mem_writedata  = m0_writedata;
        mem_byteenable = m0_write ? m0_byteenable : '1;
      end
      new_tag.valid = ~mem_write;
      new_tag.owner = gnt_owner;
    end
  end

  // stage RD_LATENCY-2 lines up with mem_readdata; the last stage lines up
  // with the return registers, so its valid bit is the readdatavalid strobe
  always_comb begin
    tag_d         = {tag_q[RD_LATENCY-2:0], new_tag};
    m0_readdata_d = m0_readdata_q;
    m1_readdata_d = m1_readdata_q;
    if (tag_q[RD_LATENCY-2].valid) begin
      if (tag_q[RD_LATENCY-2].owner) m1_readdata_d = mem_readdata;
      else                           m0_readdata_d = mem_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q         <= '0;
      m0_readdata_q <= '0;
      m1_readdata_q <= '0;
    end else begin
      tag_q         <= tag_d;
      m0_readdata_q <= m0_readdata_d;
      m1_readdata_q <= m1_readdata_d;
    end
  end

  assign m0_readdata      = m0_readdata_q;
  assign m1_readdata      = m1_readdata_q;
  assign m0_readdatavalid = tag_q[RD_LATENCY-1].valid & (tag_q[RD_LATENCY-1].owner == 1'b0);
  assign m1_readdatavalid = tag_q[RD_LATENCY-1].valid & (tag_q[RD_LATENCY-1].owner == 1'b1);

endmodule

// File: doc/osmanip_mem_arbiter.md
# osmanip_mem_arbiter

Two-requester arbiter for the single-port on-chip RAM in the osmanip system (32-bit words, 22-bit word address, 4 byte enables, 1-cycle read latency, unregistered output). It shares the RAM port between the HPS-side Avalon master (requester 0) and the cube-state engine (requester 1). Each requester gets an Avalon-MM pipelined slave interface with `waitrequest` and `readdatavalid`. At most one access is issued per cycle and read data is routed back to its owner.

## Interface
Parameters:
- `ADDR_W`, 22: word address width.
- `DATA_W`, 32: data width.
- `BE_W`, `DATA_W/8`: byte-enable width.

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high.
- `m0_read`, `m0_write`  in  1  requester 0 read / write command.
- `m0_address`  in  ADDR_W  requester 0 word address.
- `m0_byteenable`  in  BE_W  requester 0 byte lanes.
- `m0_writedata`  in  DATA_W  requester 0 write data.
- `m0_waitrequest`  out  1  command not accepted this cycle.
- `m0_readdata`  out  DATA_W  registered read data.
- `m0_readdatavalid`  out  1  one-cycle strobe qualifying `m0_readdata`.
- `m1_*`  same set as `m0_*`, for requester 1.
- `mem_address`  out  ADDR_W  to RAM.
- `mem_byteenable`  out  BE_W  to RAM.
- `mem_chipselect`  out  1  to RAM.
- `mem_write`  out  1  to RAM.
- `mem_writedata`  out  DATA_W  to RAM.
- `mem_clken`  out  1  tied high.
- `mem_readdata`  in  DATA_W  from RAM, valid 1 cycle after address.

## Operation
- Request i is active when `mi_read | mi_write`. Read and write asserted together is illegal; treat it as write.
- Arbitration is per cycle, combinational on active requests and the priority state:
  - One active request: it is granted.
  - Both active: the requester indicated by round-robin pointer `rr` wins.
- Granted requester sees `waitrequest` = 0. A loser with an active request sees `waitrequest` = 1 and must hold its command stable.
- `waitrequest` is 0 when a requester's request is inactive.
- `rr` update: after a cycle with both requests active, `rr` moves to the loser. `rr` is unchanged otherwise.
- Grant drives the `mem_*` outputs combinationally from the winner:
  - `mem_chipselect` = 1.
  - `mem_write` = winner's write.
  - `mem_byteenable`: winner's byte enables for writes, all-ones for reads.
- No grant: `mem_chipselect` = 0, `mem_write` = 0, address/data don't-care (drive 0).
- Read tag pipeline: a 2-stage shift register of {valid, owner}.
  - Stage 1 captures granted reads.
  - Stage 2 registers `mem_readdata` into the owner's `readdata` and pulses the owner's `readdatavalid`.
- Back-to-back reads from either or both requesters are fully pipelined with no bubbles.
- Reads return in issue order. Write-then-read to the same address returns the new data, because RAM writes complete at the issue edge.

## Timing
- Reset values:
  - All `readdatavalid` = 0.
  - All `readdata` = 0.
  - Tag pipeline cleared.
  - `rr` = 0 (requester 0 favoured first).
- `mem_*` and `waitrequest` are combinational and also 0 during reset.
- Read accepted in cycle N: `mem_address` is presented in N, `mem_readdata` is valid in N+1, `mi_readdatavalid` is high in N+2. Fixed latency 2.
- Write accepted in cycle N is committed at the end of N. No response.
- Throughput: one access per cycle in aggregate. Under continuous contention each requester gets every other cycle.
- Reset asserted mid-operation: in-flight reads are discarded and no `readdatavalid` follows the reset edge. Requesters must reissue.
- A read accepted in the same cycle as a `readdatavalid` from an earlier read is legal.

## Configuration
- Macro `OSMANIP_MEM_ARB_FIXED_PRI_EN`.
- Defined: `rr` is removed and requester 0 always wins contention. Requester 1 can starve.
- Undefined: round-robin as specified above.

## Structure
- Package `osmanip_mem_pkg` holds:
  - `ADDR_W`, `DATA_W`, and `RD_LATENCY` = 2 constants.
  - Typedef `owner_t` (1 bit).
  - Typedef `rd_tag_t` = {valid, owner_t}.
- One sub-module, `osmanip_rr_arb2`: combinational 2-way grant plus the registered `rr` pointer, compiled fixed-priority under the macro.
- Top level holds the mux, tag pipeline and return registers.

## Test plan
- Reset, then m0 writes `0xDEADBEEF` to address 5 (byteenable `0xF`), then m0 reads 5 → `m0_readdatavalid` 2 cycles after accept with `0xDEADBEEF`. `m1_readdatavalid` stays 0.
- m1 writes `0x11223344` to address 9 with byteenable `0x3`, over existing `0xAAAAAAAA`, then reads 9 → returns `0xAAAA3344`.
- Both issue continuous reads of addresses 0..7 → grants alternate m0, m1, m0, …. Each requester receives its 8 words in order. No valid pulses are lost.
- Same contention with `OSMANIP_MEM_ARB_FIXED_PRI_EN` → m0 completes all 8 before m1's first accept. m1 `waitrequest` stays high throughout.
- m0 read accepted, then `reset` asserted the next cycle → no `m0_readdatavalid`. Post-reset state: `rr` = 0, all outputs 0.
- m0 writes `0x5` to address 3 while m1 reads address 3 in the following cycle → m1 receives `0x5` at latency 2.
